// File: rtl/bit16_div.sv
// bit16_div: sequential 16-bit restoring divider, one quotient bit per clock.
// Define BIT16_DIV_SIGNED_EN for two's-complement operands (truncating division).
module bit16_div (
    input  logic        clk,
    input  logic        arst,
    input  logic        srst,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic        op_ld,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic        div_busy,
    output logic        div_done,
    output logic        div_zero
);

    logic [15:0] r_acc;
    logic [15:0] r_q;
    logic [15:0] r_div;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_zero;
    logic [15:0] r_quot;
    logic [15:0] r_rem;

    logic [16:0] w_t;
    logic        w_neg;
    logic [15:0] w_acc_nx;
    logic [15:0] w_q_nx;
    logic [15:0] w_opa_core;
    logic [15:0] w_opb_core;
    logic [15:0] w_quot_fin;
    logic [15:0] w_rem_fin;

    // Trial subtraction; bit 16 of the difference is the borrow, so the
    // partial remainder itself never needs a stored 17th bit.
    always_comb begin
        w_t      = {r_acc, r_q[15]} - {1'b0, r_div};
        w_neg    = w_t[16];
        w_acc_nx = w_neg ? {r_acc[14:0], r_q[15]} : w_t[15:0];
        w_q_nx   = {r_q[14:0], ~w_neg};
    end

`ifdef BIT16_DIV_SIGNED_EN
    logic r_sgn_q;
    logic r_sgn_r;

    function automatic logic [15:0] f_mag(input logic signed [15:0] v);
        logic signed [15:0] n;
        n = -v;
        return v[15] ? $unsigned(n) : $unsigned(v);
    endfunction

    function automatic logic [15:0] f_neg(input logic [15:0] v);
        return 16'd0 - v;
    endfunction

    // Zero divisor: magnitude core gives all-ones; force it so the quotient
    // is not negated. Remainder re-signed with the dividend equals opa.
    always_comb begin
        w_opa_core = f_mag($signed(opa));
        w_opb_core = f_mag($signed(opb));
        w_quot_fin = r_zero  ? 16'hFFFF :
                     r_sgn_q ? f_neg(w_q_nx) : w_q_nx;
        w_rem_fin  = r_sgn_r ? f_neg(w_acc_nx) : w_acc_nx;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sgn_q <= 1'b0;
            r_sgn_r <= 1'b0;
        end else if (srst) begin
            r_sgn_q <= 1'b0;
            r_sgn_r <= 1'b0;
        end else if (op_ld) begin
            r_sgn_q <= opa[15] ^ opb[15];
            r_sgn_r <= opa[15];
        end
    end
`else
    always_comb begin
        w_opa_core = opa;
        w_opb_core = opb;
        w_quot_fin = w_q_nx;
        w_rem_fin  = w_acc_nx;
    end
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_zero <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
        end else if (srst) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_zero <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
        end else begin
            r_done <= 1'b0;
            if (op_ld) begin
                r_div  <= w_opb_core;
                r_q    <= w_opa_core;
                r_acc  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
                r_zero <= (opb == 16'd0);
            end else if (r_busy) begin
                r_acc <= w_acc_nx;
                r_q   <= w_q_nx;
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_quot <= w_quot_fin;
                    r_rem  <= w_rem_fin;
                end
            end
        end
    end

    assign quot     = r_quot;
    assign rem      = r_rem;
    assign div_busy = r_busy;
    assign div_done = r_done;
    assign div_zero = r_zero;

endmodule

// File: tb/tb_bit16_div.sv
// Self-checking bench for bit16_div against an arithmetic reference model.
// Honours BIT16_DIV_SIGNED_EN the same way as the design.
module tb_bit16_div;

    logic        clk;
    logic        arst;
    logic        srst;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        op_ld;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        div_busy;
    logic        div_done;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    localparam int MAXWAIT = 40;

    bit16_div dut (
        .clk     (clk),
        .arst    (arst),
        .srst    (srst),
        .opa     (opa),
        .opb     (opb),
        .op_ld   (op_ld),
        .quot    (quot),
        .rem     (rem),
        .div_busy(div_busy),
        .div_done(div_done),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {quotient, remainder} from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        int q;
        int r;
        if (b == 16'd0) return {16'hFFFF, a};
`ifdef BIT16_DIV_SIGNED_EN
        q = int'($signed(a)) / int'($signed(b));
        r = int'($signed(a)) % int'($signed(b));
`else
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
`endif
        return {q[15:0], r[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        opa   = a;
        opb   = b;
        op_ld = 1'b1;
        @(negedge clk);
        op_ld = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!div_done && cyc < MAXWAIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] exp;
        exp = model(a, b);
        chk({tag, " quot"}, 32'(quot), 32'(exp[31:16]));
        chk({tag, " rem"}, 32'(rem), 32'(exp[15:0]));
        chk({tag, " zero"}, 32'(div_zero), 32'(b == 16'd0));
        chk({tag, " busy"}, 32'(div_busy), 32'd0);
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b);
        int cyc;
        load(a, b);
        chk({tag, " busy_start"}, 32'(div_busy), 32'd1);
        wait_done(cyc);
        chk({tag, " latency"}, 32'(cyc), 32'd16);
        check_result(tag, a, b);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(div_done), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] exp_a;
        logic [15:0] ra;
        logic [15:0] rb;

        arst  = 1'b1;
        srst  = 1'b0;
        op_ld = 1'b0;
        opa   = '0;
        opb   = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {quot, rem}, 32'd0);
        chk("reset flags", {29'd0, div_busy, div_done, div_zero}, 32'd0);
        arst = 1'b0;

        run("100/7", 16'd100, 16'd7);
        run("FFFF/1", 16'hFFFF, 16'h0001);
        run("3/FFFF", 16'h0003, 16'hFFFF);
        run("div0", 16'h1234, 16'h0000);
        run("-100/7", 16'hFF9C, 16'd7);
        run("100/-7", 16'd100, 16'hFFF9);
        run("-32768/-1", 16'h8000, 16'hFFFF);
        run("0/5", 16'h0000, 16'd5);

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            run("random", ra, rb);
        end

        // Restart mid-operation: first operation never completes.
        run("pre-restart", 16'd77, 16'd4);
        load(16'd100, 16'd7);
        repeat (4) @(negedge clk);
        chk("restart held quot", 32'(quot), 32'd19);
        load(16'd50, 16'd5);
        wait_done(cyc);
        chk("restart latency", 32'(cyc), 32'd16);
        check_result("restart", 16'd50, 16'd5);

        // Synchronous clear in the middle of an iteration.
        load(16'd100, 16'd7);
        repeat (8) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("srst outputs", {quot, rem}, 32'd0);
        chk("srst flags", {29'd0, div_busy, div_done, div_zero}, 32'd0);
        wait_done(cyc);
        chk("srst no done", 32'(cyc), 32'(MAXWAIT));

        // srst beats op_ld in the same cycle.
        run("pre-srstld", 16'd9, 16'd2);
        @(negedge clk);
        opa   = 16'd100;
        opb   = 16'd0;
        op_ld = 1'b1;
        srst  = 1'b1;
        @(negedge clk);
        op_ld = 1'b0;
        srst  = 1'b0;
        chk("srst+ld busy", {30'd0, div_busy, div_zero}, 32'd0);
        chk("srst+ld quot", 32'(quot), 32'd0);

        // Asynchronous reset takes effect without a clock edge.
        run("pre-arst", 16'd1000, 16'd3);
        load(16'd500, 16'd0);
        repeat (3) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        chk("arst outputs", {quot, rem}, 32'd0);
        chk("arst flags", {29'd0, div_busy, div_done, div_zero}, 32'd0);
        @(negedge clk);
        arst = 1'b0;

        // Back-to-back: reload in the done cycle.
        load(16'd1000, 16'd7);
        wait_done(cyc);
        chk("b2b first latency", 32'(cyc), 32'd16);
        check_result("b2b first", 16'd1000, 16'd7);
        exp_a = model(16'd1000, 16'd7);
        opa   = 16'd4321;
        opb   = 16'd12;
        op_ld = 1'b1;
        @(negedge clk);
        op_ld = 1'b0;
        chk("b2b done once", 32'(div_done), 32'd0);
        chk("b2b busy", 32'(div_busy), 32'd1);
        chk("b2b held quot", 32'(quot), 32'(exp_a[31:16]));
        wait_done(cyc);
        chk("b2b second latency", 32'(cyc), 32'd16);
        check_result("b2b second", 16'd4321, 16'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
